// File: rtl/cache_pkg.sv
// cache_pkg: shared definitions for the L2 request arbiter.
//   ARB_IDLE/ARB_BUSY/ARB_GAP : arbiter state encoding
//   ARB_TIMEOUT_CYCLES        : default watchdog limit (used with L2_ARB_TIMEOUT_EN)
package cache_pkg;

  localparam logic [1:0] ARB_IDLE = 2'b00;
  localparam logic [1:0] ARB_BUSY = 2'b01;
  localparam logic [1:0] ARB_GAP  = 2'b10;

  localparam int unsigned ARB_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    ST_IDLE = ARB_IDLE,
    ST_BUSY = ARB_BUSY,
    ST_GAP  = ARB_GAP
  } arb_state_e;

endpackage

// File: rtl/l2_req_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   pend_i  : pending requesters
//   ptr_i   : index with highest priority this round
//   idx_o   : first pending index at or after ptr_i (modulo NUM_REQ)
//   any_o   : at least one requester pending
module rr_pick #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pend_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [IDX_W:0] cand;

  // Walk from the farthest offset down to offset 0 so the candidate
  // closest to ptr_i is the last (winning) assignment.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (pend_i[cand[IDX_W-1:0]]) begin
        idx_o = cand[IDX_W-1:0];
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_req_arbiter.sv
// l2_req_arbiter: round-robin sharing of one L2 port between NUM_REQ L1 requesters.
// One transaction at a time; L2 command held stable until l2_ready_i, response
// routed back to the granted requester, then one quiet GAP cycle.
// Optional feature macro: L2_ARB_TIMEOUT_EN (BUSY watchdog, raises req_err_o).
// Ports:
//   clk, rst_n       : clock, async active-low reset
//   req_addr_i       : NUM_REQ packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata_i      : NUM_REQ packed write data
//   req_read_i/write : per-requester command levels
//   req_ready_o      : one-cycle completion pulse to granted requester
//   req_hit_o        : L2 hit flag, valid with req_ready_o
//   req_rdata_o      : read data broadcast, valid with req_ready_o
//   req_err_o        : timeout pulse (0 unless L2_ARB_TIMEOUT_EN)
//   l2_*_o           : command to L2; l2_*_i : L2 response
//
// state | meaning
// IDLE  | pick next pending requester, latch its command
// BUSY  | command driven to L2, waiting for l2_ready_i
// GAP   | one cycle without command so L2 returns to idle
module l2_req_arbiter
  import cache_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
  input  logic [NUM_REQ-1:0]            req_read_i,
  input  logic [NUM_REQ-1:0]            req_write_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            req_hit_o,
  output logic [DATA_WIDTH-1:0]         req_rdata_o,
  output logic [NUM_REQ-1:0]            req_err_o,
  output logic [ADDR_WIDTH-1:0]         l2_addr_o,
  output logic [DATA_WIDTH-1:0]         l2_wdata_o,
  output logic                          l2_read_o,
  output logic                          l2_write_o,
  input  logic [DATA_WIDTH-1:0]         l2_rdata_i,
  input  logic                          l2_ready_i,
  input  logic                          l2_hit_i
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("l2_req_arbiter: NUM_REQ must be 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("l2_req_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        grant_q, grant_d, rr_ptr_q, rr_ptr_d, rr_next;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d, addr_sel;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, wdata_sel, rdata_q, rdata_d;
  logic                    rd_q, rd_d, wr_q, wr_d, rd_sel, wr_sel;
  logic [NUM_REQ-1:0]      rdy_q, rdy_d, hit_q, hit_d, grant_oh, pend;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_any;

  assign pend = req_read_i | req_write_i;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .pend_i (pend),
    .ptr_i  (rr_ptr_q),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // Mux the picked requester's command and decode the held grant to one-hot.
  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    rd_sel    = 1'b0;
    wr_sel    = 1'b0;
    grant_oh  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        addr_sel  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_sel = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        rd_sel    = req_read_i[i];
        wr_sel    = req_write_i[i];
      end
      if (grant_q == IDX_W'(i)) begin
        grant_oh[i] = 1'b1;
      end
    end
  end

  assign rr_next = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

`ifdef L2_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  assign req_err_o = err_q;
`else
  assign req_err_o = '0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    rdy_d    = '0;
    hit_d    = '0;
`ifdef L2_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          addr_d  = addr_sel;
          wdata_d = wdata_sel;
          // write wins when both levels are high
          wr_d    = wr_sel;
          rd_d    = rd_sel & ~wr_sel;
`ifdef L2_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
`ifdef L2_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (l2_ready_i) begin
          rdata_d  = l2_rdata_i;
          hit_d    = grant_oh & {NUM_REQ{l2_hit_i}};
          rdy_d    = grant_oh;
          rd_d     = 1'b0;
          wr_d     = 1'b0;
          rr_ptr_d = rr_next;
          state_d  = ST_GAP;
        end
`ifdef L2_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d    = grant_oh;
          rd_d     = 1'b0;
          wr_d     = 1'b0;
          rr_ptr_d = rr_next;
          state_d  = ST_GAP;
        end
`endif
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      rdy_q    <= '0;
      hit_q    <= '0;
`ifdef L2_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      rdy_q    <= rdy_d;
      hit_q    <= hit_d;
`ifdef L2_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign l2_addr_o   = addr_q;
  assign l2_wdata_o  = wdata_q;
  assign l2_read_o   = rd_q;
  assign l2_write_o  = wr_q;
  assign req_ready_o = rdy_q;
  assign req_hit_o   = hit_q;
  assign req_rdata_o = rdata_q;

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Bench for l2_req_arbiter: transaction-level reference model compared every
// cycle, an L2 responder with programmable latency, and directed scenarios
// with literal expectations. Define L2_ARB_TIMEOUT_EN to include the timeout case.
module tb_l2_req_arbiter;

  localparam int N   = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_read, req_write;
  logic [N-1:0]    req_ready_o, req_hit_o, req_err_o;
  logic [DW-1:0]   req_rdata_o;
  logic [AW-1:0]   l2_addr_o;
  logic [DW-1:0]   l2_wdata_o;
  logic            l2_read_o, l2_write_o;
  logic [DW-1:0]   l2_rdata;
  logic            l2_ready, l2_hit;

  always #5 clk = ~clk;

  l2_req_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_read_i(req_read), .req_write_i(req_write),
    .req_ready_o(req_ready_o), .req_hit_o(req_hit_o), .req_rdata_o(req_rdata_o),
    .req_err_o(req_err_o),
    .l2_addr_o(l2_addr_o), .l2_wdata_o(l2_wdata_o),
    .l2_read_o(l2_read_o), .l2_write_o(l2_write_o),
    .l2_rdata_i(l2_rdata), .l2_ready_i(l2_ready), .l2_hit_i(l2_hit)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- L2 responder ----------------
  int          lat = 1;   // cycles of command before ready; 0 = never answer
  logic [DW-1:0] resp_data = '0;
  logic        resp_hit = 1'b0;
  int          seen;

  always @(negedge clk) begin
    if (!rst_n) begin
      l2_ready = 1'b0; l2_rdata = '0; l2_hit = 1'b0; seen = 0;
    end else if (l2_ready) begin
      l2_ready = 1'b0; seen = 0;
    end else if (l2_read_o || l2_write_o) begin
      seen++;
      if (lat > 0 && seen == lat) begin
        l2_ready = 1'b1; l2_rdata = resp_data; l2_hit = resp_hit;
      end
    end else begin
      seen = 0;
    end
  end

  // ---------------- reference model ----------------
  // owner: requester currently holding the L2 port (-1 none)
  // quiet: cycles still to sit out after a transaction ends
  int            m_rr, m_owner, m_quiet, m_busy;
  logic          exp_rd, exp_wr;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata, exp_rdata;
  logic [N-1:0]  exp_rdy, exp_hit, exp_err;

  function automatic bit pending_at(input int j);
    bit p = 1'b0;
    for (int i = 0; i < N; i++) if (i == j) p = req_read[i] | req_write[i];
    return p;
  endfunction

  function automatic logic [N-1:0] onehot(input int j);
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) if (i == j) v[i] = 1'b1;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rr = 0; m_owner = -1; m_quiet = 0; m_busy = 0;
      exp_rd = 0; exp_wr = 0; exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
      exp_rdy = '0; exp_hit = '0; exp_err = '0;
    end else begin
      exp_rdy = '0; exp_hit = '0; exp_err = '0;
      if (m_owner >= 0) begin
        m_busy++;
        if (l2_ready) begin
          exp_rdy = onehot(m_owner);
          exp_hit = l2_hit ? onehot(m_owner) : '0;
          exp_rdata = l2_rdata;
          m_rr = (m_owner + 1) % N; m_owner = -1; m_quiet = 1;
          exp_rd = 0; exp_wr = 0;
        end
`ifdef L2_ARB_TIMEOUT_EN
        else if (m_busy == TMO) begin
          exp_err = onehot(m_owner);
          m_rr = (m_owner + 1) % N; m_owner = -1; m_quiet = 1;
          exp_rd = 0; exp_wr = 0;
        end
`endif
      end else if (m_quiet > 0) begin
        m_quiet--;
      end else begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_rr + k) % N;
          if (m_owner < 0 && pending_at(j)) begin
            m_owner = j; m_busy = 0;
            exp_addr  = req_addr[j*AW +: AW];
            exp_wdata = req_wdata[j*DW +: DW];
            exp_wr = req_write[j];
            exp_rd = req_read[j] & ~req_write[j];
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("l2_read", 64'(l2_read_o), 64'(exp_rd));
    chk("l2_write", 64'(l2_write_o), 64'(exp_wr));
    chk("req_ready", 64'(req_ready_o), 64'(exp_rdy));
    chk("req_hit", 64'(req_hit_o), 64'(exp_hit));
    chk("req_err", 64'(req_err_o), 64'(exp_err));
    if (exp_rd || exp_wr) begin
      chk("l2_addr", 64'(l2_addr_o), 64'(exp_addr));
      chk("l2_wdata", 64'(l2_wdata_o), 64'(exp_wdata));
    end
    if (exp_rdy != '0) chk("req_rdata", 64'(req_rdata_o), 64'(exp_rdata));
  end

  // ---------------- transaction monitor ----------------
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] wdata; logic rd; logic wr; int len; int gap; } cmd_t;
  typedef struct { logic [N-1:0] vec; logic [N-1:0] hit; logic [DW-1:0] rdata; } rdy_t;
  cmd_t         tq[$];
  rdy_t         rq[$];
  logic [N-1:0] eq[$];
  cmd_t         cur;
  bit           in_cmd;
  int           idle_cnt;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_cmd = 0; idle_cnt = 0;
    end else begin
      if (l2_read_o || l2_write_o) begin
        if (!in_cmd) begin
          cur.addr = l2_addr_o; cur.wdata = l2_wdata_o;
          cur.rd = l2_read_o; cur.wr = l2_write_o;
          cur.gap = idle_cnt; cur.len = 0; in_cmd = 1;
        end
        cur.len++; idle_cnt = 0;
      end else begin
        if (in_cmd) begin tq.push_back(cur); in_cmd = 0; end
        idle_cnt++;
      end
      if (req_ready_o != '0) rq.push_back('{req_ready_o, req_hit_o, req_rdata_o});
      if (req_err_o != '0) eq.push_back(req_err_o);
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic clear_logs();
    tq.delete(); rq.delete(); eq.delete();
  endtask

  task automatic wait_ready(input int n, input int budget, input string name);
    int c = 0;
    while (rq.size() < n && c < budget) begin step(); c++; end
    total++;
    if (rq.size() < n) begin
      bad++;
      $display("FAIL %s: ready_pulses=%0d required=%0d", name, rq.size(), n);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [N-1:0] FAIR_EXP [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    req_addr = '0; req_wdata = '0; req_read = '0; req_write = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // single read, requester drops its request mid-transaction
    clear_logs();
    lat = 3; resp_data = 32'hDEAD_BEEF; resp_hit = 1'b1;
    req_addr[0*AW +: AW] = 32'h0000_0040; req_read = 2'b01;
    step(); step();
    req_read = 2'b00;
    wait_ready(1, 20, "single_wait");
    chk("single_addr", 64'(tq[0].addr), 64'h40);
    chk("single_len", 64'(tq[0].len), 64'd3);
    chk("single_cmd", 64'({tq[0].rd, tq[0].wr}), 64'b10);
    chk("single_who", 64'(rq[0].vec), 64'b01);
    chk("single_hit", 64'(rq[0].hit), 64'b01);
    chk("single_rdata", 64'(rq[0].rdata), 64'hDEAD_BEEF);
    repeat (3) step();

    // read+write collision on requester 1 (pointer now at 1)
    clear_logs();
    lat = 1; resp_hit = 1'b0;
    req_addr[1*AW +: AW] = 32'h100; req_wdata[1*DW +: DW] = 32'h1234_5678;
    req_read = 2'b10; req_write = 2'b10;
    step();
    req_read = 2'b00; req_write = 2'b00;
    wait_ready(1, 20, "collide_wait");
    chk("collide_cmd", 64'({tq[0].rd, tq[0].wr}), 64'b01);
    chk("collide_wdata", 64'(tq[0].wdata), 64'h1234_5678);
    chk("collide_addr", 64'(tq[0].addr), 64'h100);
    chk("collide_who", 64'(rq[0].vec), 64'b10);
    repeat (3) step();

    // contention: both held from the same cycle
    clear_logs();
    lat = 2; resp_data = 32'h0BAD_F00D; resp_hit = 1'b1;
    req_addr[0*AW +: AW] = 32'h200; req_addr[1*AW +: AW] = 32'h300;
    req_read = 2'b11;
    wait_ready(2, 30, "contend_wait");
    req_read = 2'b00;
    chk("contend_first", 64'(rq[0].vec), 64'b01);
    chk("contend_second", 64'(rq[1].vec), 64'b10);
    chk("contend_addr0", 64'(tq[0].addr), 64'h200);
    chk("contend_addr1", 64'(tq[1].addr), 64'h300);
    chk("contend_spacing", 64'(tq[1].gap), 64'd2);
    repeat (3) step();

    // fairness over six back-to-back transactions
    clear_logs();
    lat = 1; resp_data = 32'h5555_AAAA; resp_hit = 1'b0;
    req_read = 2'b11;
    wait_ready(6, 60, "fair_wait");
    req_read = 2'b00;
    for (int i = 0; i < 6; i++) chk($sformatf("fair_grant%0d", i), 64'(rq[i].vec), 64'(FAIR_EXP[i]));
    repeat (3) step();

    // reset mid-BUSY: move pointer to 1, park a transaction, then reset
    clear_logs();
    lat = 1;
    req_addr[0*AW +: AW] = 32'h500; req_read = 2'b01;
    step();
    req_read = 2'b00;
    wait_ready(1, 20, "pre_reset_wait");
    repeat (3) step();
    lat = 0;
    req_addr[0*AW +: AW] = 32'h600; req_addr[1*AW +: AW] = 32'h700;
    req_read = 2'b11;
    step(); step();
    chk("busy_before_reset_addr", 64'(l2_addr_o), 64'h700);
    step();
    rst_n = 1'b0;
    #1;
    chk("reset_ctrl_outputs", 64'({req_ready_o, req_hit_o, req_err_o, l2_read_o, l2_write_o}), 64'd0);
    chk("reset_l2_addr", 64'(l2_addr_o), 64'd0);
    chk("reset_data", 64'({l2_wdata_o, req_rdata_o}), 64'd0);
    step(); step();
    rst_n = 1'b1;
    clear_logs();
    lat = 1;
    wait_ready(1, 20, "post_reset_wait");
    req_read = 2'b00;
    chk("post_reset_who", 64'(rq[0].vec), 64'b01);
    chk("post_reset_addr", 64'(tq[0].addr), 64'h600);
    repeat (3) step();

`ifdef L2_ARB_TIMEOUT_EN
    // watchdog: L2 never answers; pointer is at 1
    clear_logs();
    lat = 0;
    req_read = 2'b10;
    step();
    req_read = 2'b00;
    begin
      int c = 0;
      while (eq.size() < 1 && c < 40) begin step(); c++; end
      total++;
      if (eq.size() < 1) begin
        bad++;
        $display("FAIL timeout_wait: err_pulses=%0d required=1", eq.size());
      end
    end
    chk("timeout_who", 64'(eq[0]), 64'b10);
    chk("timeout_len", 64'(tq[0].len), 64'(TMO));
    repeat (4) step();
    chk("timeout_no_ready", 64'(rq.size()), 64'd0);
    chk("timeout_single_err", 64'(eq.size()), 64'd1);
`endif

    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
